radix2_mul: RTL
===============

// Module: radix2_mul
// PURPOSE
//   Sequential radix-2 shift-add multiplier; arithmetic inverse of radix2_div.
//   Accepts two WIDTH-bit operands (signed or unsigned), produces 2*WIDTH-bit product.
//   Retires one multiplier bit per cycle.
//   Sits beside radix2_div in the integer datapath behind a valid/ready op/result pair.
// PARAMETERS
//   WIDTH  8  operand width; product is 2*WIDTH bits; iteration count = WIDTH
// PORTS
//   clk           in   1        rising-edge clock
//   rst_n         in   1        asynchronous, active-low reset
//   sign          in   1        1: operands/product two's complement; 0: unsigned
//   multiplicand  in   WIDTH    operand A, sampled on accept
//   multiplier    in   WIDTH    operand B, sampled on accept
//   opn_valid     in   1        operation request
//   opn_ready     out  1        block can accept (high only in IDLE)
//   res_valid     out  1        result valid; held until consumed
//   res_ready     in   1        consumer takes result
//   result        out  2*WIDTH  product; stable while res_valid
// BEHAVIOUR
//   - Reset: one clock (clk); reset asynchronous, active-low (rst_n).
//     State=IDLE; opn_ready=1; res_valid=0; result=0; count=0; internal regs=0.
//     Assertion mid-operation aborts immediately; no partial result is emitted.
//   - FSM IDLE -> BUSY -> DONE -> IDLE.
//   - IDLE: opn_ready=1. On opn_valid at an edge (accept):
//     - latch sign, |A|, |B| and neg = sign & (A[MSB]^B[MSB]);
//     - clear accumulator; count=0; go BUSY.
//     - Magnitudes are WIDTH-bit unsigned: -2^(WIDTH-1) -> 2^(WIDTH-1), no overflow.
//   - BUSY: opn_ready=0. Each cycle:
//     - if the multiplier LSB is 1, add the multiplicand into the upper accumulator half (WIDTH+1-bit sum keeps the carry);
//     - shift the {carry, acc, multiplier} register right by 1; count++.
//     - After WIDTH iterations go DONE.
//   - DONE entry: result = neg ? -acc : acc (2*WIDTH-bit two's complement). res_valid=1.
//     - Latency: res_valid rises exactly WIDTH+1 edges after the accepting edge.
//     - The operand value does not shorten latency: 0 or 1 operands still take WIDTH+1 edges.
//   - DONE: hold result and res_valid until res_valid & res_ready at an edge.
//     Then res_valid=0 and state=IDLE. result keeps its last value.
//     - opn_valid ignored outside IDLE (opn_ready=0); no queuing.
//     - Back-to-back: next accept at earliest the edge after the result handshake.
//     - res_ready while res_valid=0 has no effect.
//   - Input changes while BUSY/DONE do not affect the product (operands latched).
//   - Product always fits 2*WIDTH bits:
//     signed range -2^(2W-2)+2^(W-1) .. 2^(2W-2); unsigned max (2^W-1)^2.
// STRUCTURE
//   - Shared package radix2_pkg (also used by radix2_div):
//     - state encoding localparams S_IDLE/S_BUSY/S_DONE;
//     - default WIDTH;
//     - counter width function clog2(WIDTH+1).
//   - One sub-module: radix2_cneg (combinational conditional two's-complement negate, width-parameterised).
//     Instanced twice at the input for abs (WIDTH); once at the output for sign fix (2*WIDTH).
//   - Top holds the FSM, counter, accumulator/shift register and handshake.
// TESTING
//   1. Unsigned 255*255 (sign=0, A=8'hFF, B=8'hFF) -> result 16'hFE01, res_valid at accept+9 edges.
//   2. Signed -128*-128 (8'h80, 8'h80, sign=1) -> 16'h4000; signed -128*1 -> 16'hFF80; 7*-3 -> 16'hFFEB.
//   3. Backpressure: hold res_ready=0 for 5 cycles after res_valid -> result/res_valid stable.
//      Pulse opn_valid meanwhile -> ignored (opn_ready=0).
//   4. Back-to-back with res_ready=1: 12*10 then 0*77 -> 16'h0078 then 16'h0000.
//      Second accept is on the edge after the first handshake; each takes 9 edges.
//   5. Reset mid-BUSY (rst_n low after 4 iterations) -> immediate IDLE, res_valid=0, result=0.
//      A fresh 3*5 then gives 16'h000F.
//   6. Randomised signed/unsigned sweep vs a reference model.
//      Also change operands during BUSY -> no effect on result.

Source files
------------

// File: rtl/radix2_pkg.sv
// Shared definitions for the radix-2 multiplier and divider datapath blocks.
// Holds the FSM state encoding, the default operand width and the counter sizing helper.
package radix2_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // The iteration counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/radix2_cneg.sv
// Combinational conditional two's-complement negate.
// Used for operand magnitudes on the way in and for the sign fix on the way out.
module radix2_cneg #(
    parameter int W = 8
) (
    input  logic         neg,
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);

    assign y = neg ? (~a + W'(1)) : a;

endmodule

// File: rtl/radix2_mul.sv
// Sequential radix-2 shift-add multiplier retiring one multiplier bit per cycle.
// Operates on magnitudes and applies the product sign on the transition into DONE.
module radix2_mul
    import radix2_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sign,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic               opn_valid,
    output logic               opn_ready,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] result
);

    localparam int CW = cnt_width(WIDTH);

    state_t               state;
    state_t               state_next;
    logic [CW-1:0]        count;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     mplr;
    logic [WIDTH-1:0]     mcand;
    logic                 neg;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   fixed_prod;
    logic                 iter_done;

    radix2_cneg #(.W(WIDTH)) u_abs_a (
        .neg (sign & multiplicand[WIDTH-1]),
        .a   (multiplicand),
        .y   (abs_a)
    );

    radix2_cneg #(.W(WIDTH)) u_abs_b (
        .neg (sign & multiplier[WIDTH-1]),
        .a   (multiplier),
        .y   (abs_b)
    );

    radix2_cneg #(.W(2 * WIDTH)) u_fix (
        .neg (neg),
        .a   ({acc, mplr}),
        .y   (fixed_prod)
    );

    assign iter_done = (count == CW'(WIDTH));
    assign opn_ready = (state == S_IDLE);
    assign res_valid = (state == S_DONE);

    // The extra top bit of the sum keeps the carry so the shift never loses it.
    assign sum = {1'b0, acc} + ({1'b0, mcand} & {(WIDTH + 1){mplr[0]}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (opn_valid) state_next = S_BUSY;
            S_BUSY:  if (iter_done) state_next = S_DONE;
            S_DONE:  if (res_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            acc    <= '0;
            mplr   <= '0;
            mcand  <= '0;
            neg    <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (opn_valid) begin
                        mcand <= abs_a;
                        mplr  <= abs_b;
                        acc   <= '0;
                        count <= '0;
                        neg   <= sign & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                    end
                end
                S_BUSY: begin
                    if (iter_done) begin
                        result <= fixed_prod;
                    end else begin
                        acc   <= sum[WIDTH:1];
                        mplr  <= {sum[0], mplr[WIDTH-1:1]};
                        count <= count + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
